instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream feeder for simple_cpu.
- Holds a small loadable program memory and a program counter (PC).
- Presents one 20-bit instruction at a time to the CPU's instruction input using a valid/ready handshake.
- Handles sequential fetch, CPU-requested jumps, halt detection, and program load while idle.

Parameters:
INSTR_WIDTH, 20, instruction width; must match the CPU's instruction width.
PC_BITS, 5, PC/address width; program memory depth = 2**PC_BITS (32 words).
HALT_OPCODE, 4'hF, opcode value (instr[INSTR_WIDTH-1 -: 4]) that stops fetching.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- prog_wen  input  1  program-memory write enable; honoured in IDLE and HALTED only.
- prog_addr  input  PC_BITS  program-memory write address.
- prog_data  input  INSTR_WIDTH  program-memory write data.
- start  input  1  one-cycle pulse; begins execution from address 0.
- cpu_ready  input  1  CPU accepts the presented instruction this cycle.
- jump_en  input  1  redirect the fetch; sampled only on a handshake cycle.
- jump_addr  input  PC_BITS  redirect target.
- instruction  output  INSTR_WIDTH  registered instruction to the CPU.
- instr_valid  output  1  instruction is valid.
- pc_out  output  PC_BITS  address of the presented instruction.
- halted  output  1  high in HALTED.
- retired_count  output  16  retired-instruction counter (see Optional Feature).

Behaviour:
- Reset: state IDLE; instruction, instr_valid, pc_out, halted and retired_count all 0. Program memory is not cleared.
- Reset mid-run: aborts immediately, with the same values as above.
- States: IDLE, RUN, HALTED.
- Memory: sync write, async read. A write occurs on any cycle with prog_wen=1 in IDLE/HALTED; prog_wen is ignored in RUN.
- IDLE/HALTED -> RUN: start=1 and prog_wen=0. Next cycle: pc_out=0, instruction=mem[0], instr_valid=1, halted=0.
  - start and prog_wen both high: the write is done, start is ignored.
  - start is ignored in RUN.
- Handshake: instr_valid=1 and cpu_ready=1 in RUN = "consume". Without a consume, instruction, pc_out and instr_valid hold; 1 cycle of latency start -> valid.
- On consume, one branch applies, in priority order:
  1. Consumed opcode == HALT_OPCODE -> HALTED; instr_valid=0, halted=1; instruction and pc_out hold. jump_en is ignored.
  2. Else if jump_en -> pc_out=jump_addr, instruction=mem[jump_addr], next cycle.
  3. Else -> pc_out=pc_out+1 mod 2**PC_BITS (31 wraps to 0), instruction=mem[new pc].
- Back-to-back consumes deliver one instruction per cycle with no bubble.
- jump_en without a consume has no effect.
- A jump to the current pc re-presents the same word, which is legal.

Optional Feature:
- Macro: INSTR_FETCH_RETIRE_COUNT_EN.
- Defined: retired_count increments on every consume, including the HALT word.
  - Saturates at 16'hFFFF.
  - Cleared on rst and on an accepted start.
- Undefined: retired_count is tied to 0 and no counter flops exist. The port is always present.

Decomposition:
- Package fetch_pkg holds:
  - state enum {IDLE, RUN, HALTED};
  - INSTR_WIDTH and PC_BITS defaults;
  - HALT_OPCODE;
  - OPCODE_W=4 constant and opcode-field extract helper.
- One sub-module, fetch_prog_mem: 2**PC_BITS x INSTR_WIDTH register array, sync write port, async read port.
- FSM, PC, output register and counter stay in the top.

Test Plan:
- Load and stream: load mem[0..3]=20'h1_0001, 20'h2_0002, 20'h3_0003, 20'hF_0000; pulse start; hold cpu_ready=1.
  -> instructions 1_0001, 2_0002, 3_0003, F_0000 on consecutive cycles with pc_out 0..3; then halted=1, instr_valid=0; retired_count=4 if enabled.
- Stall: deassert cpu_ready for 3 cycles while 2_0002 is presented.
  -> instruction and pc_out=1 stay stable for all 3 cycles; pc advances to 2 one cycle after cpu_ready returns.
- Jump: jump_en=1, jump_addr=5'd20 on consume of pc 1, mem[20]=20'h7_00AA.
  -> next cycle pc_out=20, instruction=7_00AA.
  - Separately, jump_en=1 with cpu_ready=0 -> no change.
- Wrap: mem[31]=20'h4_1234, mem[0]=20'h5_0000, no halt; jump to 31 then consume.
  -> pc_out 31 -> 0, instruction 4_1234 -> 5_0000.
- Halt precedence: consume F_0000 with jump_en=1, jump_addr=9 -> HALTED, pc_out holds.
- Load rules and reset:
  - prog_wen during RUN -> memory unchanged (read back after halt).
  - rst mid-RUN -> next cycle instr_valid=0, pc_out=0, halted=0, state IDLE.
  - start with prog_wen=1 in IDLE -> no start.
  - start in HALTED -> restarts at pc 0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit:
//               FSM state encoding, default widths, the HALT opcode and an
//               opcode-field extract helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Default geometry; the top exposes these as overridable parameters.
  localparam int DEF_INSTR_WIDTH = 20;
  localparam int DEF_PC_BITS     = 5;

  // The opcode occupies the most significant OPCODE_W bits of a word.
  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] DEF_HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  // Opcode field of a default-width instruction word.
  function automatic logic [OPCODE_W-1:0] get_opcode(
    input logic [DEF_INSTR_WIDTH-1:0] instr
  );
    return instr[DEF_INSTR_WIDTH-1 -: OPCODE_W];
  endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prog_mem
// Description : Program memory, 2**PC_BITS words of INSTR_WIDTH bits.
//               Synchronous write port, asynchronous (combinational) read.
//               Contents are not reset.
// Ports       : clk      - system clock
//               we       - write enable (already qualified by the caller)
//               wr_addr  - write address
//               wr_data  - write data
//               rd_addr  - read address
//               rd_data  - read data, combinational from rd_addr
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prog_mem
  import fetch_pkg::*;
#(
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int PC_BITS     = DEF_PC_BITS
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [PC_BITS-1:0]     wr_addr,
  input  logic [INSTR_WIDTH-1:0] wr_data,
  input  logic [PC_BITS-1:0]     rd_addr,
  output logic [INSTR_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** PC_BITS;

  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : fetch_prog_mem
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction feeder for simple_cpu. Holds a loadable program
//               memory and a PC, and presents one registered instruction at a
//               time over a valid/ready handshake. Supports sequential fetch,
//               jumps requested on a handshake, HALT-opcode detection and
//               program load while IDLE or HALTED.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               prog_wen/addr/data - program load (ignored in RUN)
//               start           - begin execution at address 0
//               cpu_ready       - CPU accepts the presented instruction
//               jump_en/addr    - redirect, sampled on a handshake only
//               instruction     - presented instruction (registered)
//               instr_valid     - instruction is valid
//               pc_out          - address of the presented instruction
//               halted          - high in HALTED
//               retired_count   - consumed-instruction counter
// Config      : INSTR_FETCH_RETIRE_COUNT_EN - when defined, retired_count is
//               a saturating 16-bit counter; otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int                  PC_BITS     = DEF_PC_BITS,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = DEF_HALT_OPCODE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_wen,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   start,
  input  logic                   cpu_ready,
  input  logic                   jump_en,
  input  logic [PC_BITS-1:0]     jump_addr,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc_out,
  output logic                   halted,
  output logic [15:0]            retired_count
);

  fetch_state_e           state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;

  logic                   mem_we;
  logic [PC_BITS-1:0]     rd_addr;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic                   start_acc;
  logic                   consume;
  logic                   is_halt;
  logic [OPCODE_W-1:0]    cur_opcode;

  assign cur_opcode = instruction_opcode(instr_q);
  assign is_halt    = (cur_opcode == HALT_OPCODE);

  // Opcode of the presented word for any configured width.
  function automatic logic [OPCODE_W-1:0] instruction_opcode(
    input logic [INSTR_WIDTH-1:0] instr
  );
    return instr[INSTR_WIDTH-1 -: OPCODE_W];
  endfunction

  // Writes are only honoured outside RUN so a running program is immutable.
  assign mem_we = prog_wen && (state_q != RUN);

  fetch_prog_mem #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .PC_BITS     (PC_BITS)
  ) u_prog_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Event decode and read address are kept apart from the next-state block
  // so the combinational memory read does not form a loop through one
  // process. The read address is the PC the next presented word will have.
  always_comb begin
    start_acc = 1'b0;
    consume   = 1'b0;
    rd_addr   = pc_q;
    case (state_q)
      IDLE, HALTED: begin
        // A simultaneous write wins over start.
        if (start && !prog_wen) begin
          start_acc = 1'b1;
          rd_addr   = '0;
        end
      end
      RUN: begin
        if (valid_q && cpu_ready) begin
          consume = 1'b1;
          rd_addr = jump_en ? jump_addr : (pc_q + 1'b1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (start_acc) begin
      state_d  = RUN;
      pc_d     = rd_addr;
      instr_d  = rd_data;
      valid_d  = 1'b1;
      halted_d = 1'b0;
    end else if (consume) begin
      if (is_halt) begin
        // HALT outranks a jump; the halt word and its PC stay visible.
        state_d  = HALTED;
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end else begin
        pc_d    = rd_addr;
        instr_d = rd_data;
      end
    end else if (state_q != IDLE && state_q != RUN && state_q != HALTED) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_q;
  assign halted      = halted_q;

`ifdef INSTR_FETCH_RETIRE_COUNT_EN
  logic [15:0] retired_q, retired_d;

  // Every consume retires a word, the HALT word included; the counter
  // saturates and restarts from zero on each accepted start.
  always_comb begin
    retired_d = retired_q;
    if (start_acc) begin
      retired_d = '0;
    end else if (consume && (retired_q != 16'hFFFF)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_wen;
  logic [4:0]  prog_addr;
  logic [19:0] prog_data;
  logic        start;
  logic        cpu_ready;
  logic        jump_en;
  logic [4:0]  jump_addr;
  logic [19:0] instruction;
  logic        instr_valid;
  logic [4:0]  pc_out;
  logic        halted;
  logic [15:0] retired_count;

  int n_vec  = 0;
  int n_miss = 0;

  instr_fetch_unit u_dut (
    .clk           (clk),
    .rst           (rst),
    .prog_wen      (prog_wen),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .start         (start),
    .cpu_ready     (cpu_ready),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .halted        (halted),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [19:0] d);
    prog_wen  = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_wen  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [4:0] pc,
                           input logic [19:0] ins, input logic v,
                           input logic h);
    check_val({tag, ".pc"},     {27'd0, pc_out},      {27'd0, pc});
    check_val({tag, ".instr"},  {12'd0, instruction}, {12'd0, ins});
    check_val({tag, ".valid"},  {31'd0, instr_valid}, {31'd0, v});
    check_val({tag, ".halted"}, {31'd0, halted},      {31'd0, h});
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef INSTR_FETCH_RETIRE_COUNT_EN
    return 16'(n);
`else
    return 16'd0 & 16'(n);
`endif
  endfunction

  initial begin
    rst = 1'b1; prog_wen = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; cpu_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
    tick(); tick();
    rst = 1'b0;
    check_out("reset", 5'd0, 20'h0, 1'b0, 1'b0);
    check_val("reset.cnt", {16'd0, retired_count}, {16'd0, exp_cnt(0)});

    load(5'd0,  20'h1_0001);
    load(5'd1,  20'h2_0002);
    load(5'd2,  20'h3_0003);
    load(5'd3,  20'hF_0000);
    load(5'd20, 20'h7_00AA);
    load(5'd31, 20'h4_1234);

    // start together with a write: write happens, start is ignored
    start = 1'b1; prog_wen = 1'b1; prog_addr = 5'd5; prog_data = 20'h6_0006;
    tick();
    start = 1'b0; prog_wen = 1'b0;
    check_out("start_wen", 5'd0, 20'h0, 1'b0, 1'b0);

    // Run 1: stream with a stall on pc 1
    pulse_start();
    check_out("run1.p0", 5'd0, 20'h1_0001, 1'b1, 1'b0);
    cpu_ready = 1'b1;
    tick();
    check_out("run1.p1", 5'd1, 20'h2_0002, 1'b1, 1'b0);
    cpu_ready = 1'b0; jump_en = 1'b1; jump_addr = 5'd20;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall", 5'd1, 20'h2_0002, 1'b1, 1'b0);
    end
    // write attempt in RUN must be dropped
    jump_en = 1'b0; cpu_ready = 1'b1;
    prog_wen = 1'b1; prog_addr = 5'd2; prog_data = 20'hA_AAAA;
    tick();
    prog_wen = 1'b0;
    check_out("run1.p2", 5'd2, 20'h3_0003, 1'b1, 1'b0);
    tick();
    check_out("run1.p3", 5'd3, 20'hF_0000, 1'b1, 1'b0);
    tick();
    check_out("run1.halt", 5'd3, 20'hF_0000, 1'b0, 1'b1);
    check_val("run1.cnt", {16'd0, retired_count}, {16'd0, exp_cnt(4)});
    cpu_ready = 1'b0;
    tick();
    check_out("run1.hold", 5'd3, 20'hF_0000, 1'b0, 1'b1);

    // Run 2: restart from HALTED, jumps, halt precedence
    pulse_start();
    check_out("run2.p0", 5'd0, 20'h1_0001, 1'b1, 1'b0);
    check_val("run2.cnt0", {16'd0, retired_count}, {16'd0, exp_cnt(0)});
    cpu_ready = 1'b1;
    tick();
    check_out("run2.p1", 5'd1, 20'h2_0002, 1'b1, 1'b0);
    jump_en = 1'b1; jump_addr = 5'd20;
    tick();
    check_out("jump20", 5'd20, 20'h7_00AA, 1'b1, 1'b0);
    jump_addr = 5'd31;
    tick();
    check_out("jump31", 5'd31, 20'h4_1234, 1'b1, 1'b0);
    jump_addr = 5'd2;
    tick();
    check_out("jump2", 5'd2, 20'h3_0003, 1'b1, 1'b0);
    tick();
    check_out("jump_self", 5'd2, 20'h3_0003, 1'b1, 1'b0);
    jump_en = 1'b0;
    tick();
    check_out("run2.p3", 5'd3, 20'hF_0000, 1'b1, 1'b0);
    jump_en = 1'b1; jump_addr = 5'd9;
    tick();
    jump_en = 1'b0; cpu_ready = 1'b0;
    check_out("halt_prec", 5'd3, 20'hF_0000, 1'b0, 1'b1);
    check_val("run2.cnt", {16'd0, retired_count}, {16'd0, exp_cnt(7)});

    // Run 3: wrap 31 -> 0 after reloading word 0 while HALTED
    load(5'd0, 20'h5_0000);
    pulse_start();
    check_out("run3.p0", 5'd0, 20'h5_0000, 1'b1, 1'b0);
    cpu_ready = 1'b1; jump_en = 1'b1; jump_addr = 5'd31;
    tick();
    jump_en = 1'b0;
    check_out("run3.p31", 5'd31, 20'h4_1234, 1'b1, 1'b0);
    tick();
    check_out("wrap", 5'd0, 20'h5_0000, 1'b1, 1'b0);

    // reset mid-run
    rst = 1'b1;
    tick();
    rst = 1'b0; cpu_ready = 1'b0;
    check_out("rst_run", 5'd0, 20'h0, 1'b0, 1'b0);
    check_val("rst_run.cnt", {16'd0, retired_count}, {16'd0, exp_cnt(0)});
    tick();
    check_out("rst_idle", 5'd0, 20'h0, 1'b0, 1'b0);
    // IDLE accepts start and memory survived the reset
    pulse_start();
    check_out("post_rst", 5'd0, 20'h5_0000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_instr_fetch_unit
`default_nettype wire
